seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Receive end of the reaction-timer 7-segment display interface: samples the
//  multiplexed anode/segment lines driven by the reaction_time_top display driver, decodes each
//  digit glyph, assembles 4-digit frames and publishes the displayed value as
//  binary once a frame is stable. Used as on-chip readback/self-check of the
//  display path and as the bench-side display monitor.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles an anode code must hold (valid one-hot) before its segments are sampled
//  STABLE_FRAMES  2  consecutive identical complete frames required before publishing
//  TIMEOUT_CYCLES 65535  cycles without a completed frame before stall_o asserts
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  an_i         in   4   anode lines, active-low, an_i[0] = rightmost digit
//  seg_i        in   7   segment lines, active-low, seg_i[0]=a .. seg_i[6]=g
//  digits_o     out  16  published glyph codes, [3:0]=digit0 .. [15:12]=digit3
//  value_o      out  14  published value d3*1000+d2*100+d1*10+d0 (0..9999)
//  valid_o      out  1   one-cycle pulse when digits_o/value_o update
//  glyph_err_o  out  1   published frame contains dash or unknown glyph
//  stall_o      out  1   no complete frame for TIMEOUT_CYCLES cycles
// BEHAVIOUR
//  - Reset: digits_o=16'h0000, value_o=0, valid_o=0, glyph_err_o=0, stall_o=0;
//    settle counter, seen mask, match count, previous frame all cleared. Reset
//    mid-frame discards partial frame; no publish follows until a fresh frame.
//  - Glyph decode (active-low seg inverted first): standard 0-9 -> 4'h0..4'h9;
//    all-off -> 4'hF (blank); g only -> 4'hE (dash); anything else -> 4'hD.
//  - Dwell: an_i registered each cycle. Counter clears when an_i differs from
//    its registered copy or is not exactly one-low; else increments, saturating.
//    Sample happens once per dwell, on the cycle count == SETTLE_CYCLES-1:
//    decoded glyph written to slot of active digit, seen bit set. Re-sampling
//    an already-seen slot in same frame overwrites it (last dwell wins).
//  - All anodes high or multiple low: no sample; counter held at 0.
//  - FSM SCAN -> COMPARE -> (PUBLISH) -> SCAN:
//    SCAN: collect until seen==4'b1111, then COMPARE next cycle; seen cleared.
//    COMPARE (1 cycle): frame==prev_frame ? match_cnt+1 (saturating) : match_cnt=0;
//      prev_frame<=frame. If match_cnt reaches STABLE_FRAMES-1 and frame !=
//      digits_o (or nothing yet published since reset) -> PUBLISH, else SCAN.
//    PUBLISH (1 cycle): digits_o<=frame, value_o computed, valid_o=1, -> SCAN.
//    Samples arriving during COMPARE/PUBLISH go to the next frame (not lost).
//  - Total latency: last sample of qualifying frame -> valid_o = 2 cycles.
//  - Value: blank digits count as 0; if any digit is 4'hE or 4'hD then
//    value_o=0, glyph_err_o=1, else glyph_err_o=0. Sum fits 14 bits (max 9999).
//  - Stall: cycle counter clears on every completed frame; at TIMEOUT_CYCLES
//    stall_o=1 (sticky until next completed frame, which clears it same cycle).
//  - Identical value re-displayed: no repeated valid_o pulse.
// STRUCTURE
//  - Shared package: glyph code constants (GLYPH_BLANK=4'hF, GLYPH_DASH=4'hE,
//    GLYPH_BAD=4'hD), 7-bit segment pattern constants for 0-9 and dash, FSM
//    state enum {SCAN, COMPARE, PUBLISH}.
//  - One sub-module: seg7_glyph_decode (combinational seg pattern -> 4-bit code).
//  - BCD-to-binary as shift/add constants in top; no multiplier IP.
// TESTING
//  1 Drive digits 1,2,3,4 (an 4'b0111..4'b1110), 8-cycle dwell each, 2 frames ->
//    one valid_o pulse, value_o=1234, digits_o=16'h1234, glyph_err_o=0.
//  2 Dwell 3 cycles (< SETTLE_CYCLES) on digit0 -> slot never filled, no valid_o.
//  3 Frames blank,blank,5,7 repeated -> value_o=57, digits_o=16'hFF57; repeat 10
//    more frames -> no further valid_o.
//  4 Frame with dash glyph (seg_i=7'b0111111) on digit3 -> glyph_err_o=1, value_o=0.
//  5 Alternate 1234 / 1235 each frame -> match never reached, no valid_o; then
//    hold 9999 -> valid_o, value_o=9999.
//  6 Assert reset after 3 digits sampled, release, send 0042 x2 -> single pulse,
//    value_o=42; hold an_i=4'b1111 for TIMEOUT_CYCLES -> stall_o=1.

Source files
------------

// File: rtl/seg7_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture block: glyph codes,
// active-high segment patterns (bit0 = a .. bit6 = g), frame type, FSM states
// and small helpers used when converting a captured frame to a binary value.
package seg7_scan_capture_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned VALUE_W = 14;

    // Non-numeric glyph codes
    localparam logic [CODE_W-1:0] GLYPH_BLANK = 4'hF;
    localparam logic [CODE_W-1:0] GLYPH_DASH  = 4'hE;
    localparam logic [CODE_W-1:0] GLYPH_BAD   = 4'hD;

    // Lit-segment patterns, active-high, gfedcba
    localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

    // One glyph code per digit position, [0] = rightmost digit
    typedef logic [DIGITS-1:0][CODE_W-1:0] frame_t;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        COMPARE = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // True when any digit of the frame is a dash or an unrecognised glyph
    function automatic logic frame_has_err(input frame_t f);
        logic err;
        err = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (f[i] == GLYPH_DASH || f[i] == GLYPH_BAD) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

    // Numeric weight of a glyph; blank (and any non-digit) counts as zero
    function automatic logic [CODE_W-1:0] digit_value(input logic [CODE_W-1:0] code);
        return (code > 4'h9) ? 4'h0 : code;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder.
// Ports:
//   seg    in  7  raw segment lines, active-low, seg[0]=a .. seg[6]=g
//   code_c out 4  0-9 for digits, F blank, E dash, D anything else
module seg7_glyph_decode
    import seg7_scan_capture_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic [CODE_W-1:0] code_c
);

    logic [SEG_W-1:0] lit;

    // Invert to active-high, then match against the known glyph set
    always_comb begin
        lit    = ~seg;
        code_c = GLYPH_BAD;
        case (lit)
            SEG_0:    code_c = 4'h0;
            SEG_1:    code_c = 4'h1;
            SEG_2:    code_c = 4'h2;
            SEG_3:    code_c = 4'h3;
            SEG_4:    code_c = 4'h4;
            SEG_5:    code_c = 4'h5;
            SEG_6:    code_c = 4'h6;
            SEG_7:    code_c = 4'h7;
            SEG_8:    code_c = 4'h8;
            SEG_9:    code_c = 4'h9;
            SEG_OFF:  code_c = GLYPH_BLANK;
            SEG_DASH: code_c = GLYPH_DASH;
            default:  code_c = GLYPH_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed 7-segment display: waits for each anode to
// settle, samples and decodes its glyph, assembles 4-digit frames and
// publishes the displayed value once STABLE_FRAMES identical frames are seen.
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous active-high reset
//   an_i         in   4   anode lines, active-low, an_i[0] = rightmost digit
//   seg_i        in   7   segment lines, active-low, seg_i[0]=a .. seg_i[6]=g
//   digits_o     out  16  published glyph codes, [3:0]=digit0 .. [15:12]=digit3
//   value_o      out  14  published decimal value (0..9999)
//   valid_o      out  1   one-cycle pulse when digits_o/value_o update
//   glyph_err_o  out  1   published frame holds a dash or unknown glyph
//   stall_o      out  1   no complete frame for TIMEOUT_CYCLES cycles
module seg7_scan_capture
    import seg7_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     an_i,
    input  logic [SEG_W-1:0]      seg_i,
    output logic [DIGITS*CODE_W-1:0] digits_o,
    output logic [VALUE_W-1:0]    value_o,
    output logic                  valid_o,
    output logic                  glyph_err_o,
    output logic                  stall_o
);

    localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W   = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SETTLE_W-1:0]  SETTLE_SAMPLE = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_MAX    = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [MATCH_W-1:0]   MATCH_GOAL    = MATCH_W'(STABLE_FRAMES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX   = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_ARM   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Dwell tracking and sampling
    // ------------------------------------------------------------------
    logic [DIGITS-1:0]   an_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                an_ok_c;
    logic                sample_c;
    logic [SLOT_W-1:0]   slot_c;
    logic [CODE_W-1:0]   glyph_c;

    seg7_glyph_decode u_decode (
        .seg    (seg_i),
        .code_c (glyph_c)
    );

    // Anode is usable only when unchanged since last cycle and exactly one-low
    always_comb begin
        an_ok_c  = (an_i == an_q) && $onehot(~an_i);
        sample_c = an_ok_c && (settle_q == SETTLE_SAMPLE);
        slot_c   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!an_i[i]) begin
                slot_c = SLOT_W'(i);
            end
        end
    end

    // Saturating settle counter: one sample per dwell, never repeated
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q     <= '1;
            settle_q <= '0;
        end else begin
            an_q <= an_i;
            if (!an_ok_c) begin
                settle_q <= '0;
            end else if (settle_q != SETTLE_MAX) begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_nxt_c;
    frame_t            frame_q;
    frame_t            frame_nxt_c;
    frame_t            cap_q;
    logic [DIGITS-1:0] seen_q;
    logic [DIGITS-1:0] seen_nxt_c;
    logic              done_c;

    // A frame completes on the sample that fills the last unseen slot
    always_comb begin
        frame_nxt_c = frame_q;
        seen_nxt_c  = seen_q;
        if (sample_c) begin
            frame_nxt_c[slot_c] = glyph_c;
            seen_nxt_c[slot_c]  = 1'b1;
        end
        done_c = (state_q == SCAN) && (seen_nxt_c == '1);
    end

    // The completed frame is snapshotted so the next frame can start at once
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            seen_q  <= '0;
            cap_q   <= '0;
        end else begin
            frame_q <= frame_nxt_c;
            seen_q  <= done_c ? '0 : seen_nxt_c;
            if (done_c) begin
                cap_q <= frame_nxt_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stability check and publish FSM
    // ------------------------------------------------------------------
    frame_t             prev_q;
    logic               prev_ok_q;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_nxt_c;
    logic               published_q;
    logic               compare_c;
    logic               publish_c;

    // Match count seen by the current COMPARE cycle
    always_comb begin
        match_nxt_c = '0;
        if (prev_ok_q && (cap_q == prev_q)) begin
            match_nxt_c = (match_q >= MATCH_GOAL) ? match_q : match_q + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_nxt_c;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_c = state_q;
        case (state_q)
            SCAN:    if (done_c) state_nxt_c = COMPARE;
            COMPARE: state_nxt_c = publish_c ? PUBLISH : SCAN;
            PUBLISH: state_nxt_c = SCAN;
            default: state_nxt_c = SCAN;
        endcase
    end

    // Output decode; a repeated value is suppressed against digits_o
    always_comb begin
        compare_c = 1'b0;
        publish_c = 1'b0;
        case (state_q)
            COMPARE: begin
                compare_c = 1'b1;
                publish_c = (match_nxt_c >= MATCH_GOAL) &&
                            (!published_q || (cap_q != digits_o));
            end
            default: begin
                compare_c = 1'b0;
                publish_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
            match_q   <= '0;
        end else if (compare_c) begin
            prev_q    <= cap_q;
            prev_ok_q <= 1'b1;
            match_q   <= match_nxt_c;
        end
    end

    // ------------------------------------------------------------------
    // BCD to binary by shift/add: 1000 = 1024-16-8, 100 = 64+32+4, 10 = 8+2
    // ------------------------------------------------------------------
    logic               err_c;
    logic [VALUE_W-1:0] d0_c;
    logic [VALUE_W-1:0] d1_c;
    logic [VALUE_W-1:0] d2_c;
    logic [VALUE_W-1:0] d3_c;
    logic [VALUE_W-1:0] value_c;

    always_comb begin
        err_c   = frame_has_err(cap_q);
        d0_c    = VALUE_W'(digit_value(cap_q[0]));
        d1_c    = VALUE_W'(digit_value(cap_q[1]));
        d2_c    = VALUE_W'(digit_value(cap_q[2]));
        d3_c    = VALUE_W'(digit_value(cap_q[3]));
        value_c = (d3_c << 10) - (d3_c << 4) - (d3_c << 3)
                + (d2_c << 6) + (d2_c << 5) + (d2_c << 2)
                + (d1_c << 3) + (d1_c << 1)
                + d0_c;
        if (err_c) begin
            value_c = '0;
        end
    end

    // Published outputs: valid_o is high during the PUBLISH cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_o    <= '0;
            value_o     <= '0;
            glyph_err_o <= 1'b0;
            valid_o     <= 1'b0;
            published_q <= 1'b0;
        end else begin
            valid_o <= publish_c;
            if (publish_c) begin
                digits_o    <= cap_q;
                value_o     <= value_c;
                glyph_err_o <= err_c;
                published_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdog: counts cycles since the last completed frame
    // ------------------------------------------------------------------
    logic [TIMEOUT_W-1:0] idle_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q  <= '0;
            stall_o <= 1'b0;
        end else if (done_c) begin
            idle_q  <= '0;
            stall_o <= 1'b0;
        end else begin
            if (idle_q != TIMEOUT_MAX) begin
                idle_q <= idle_q + 1'b1;
            end
            if (idle_q >= TIMEOUT_ARM) begin
                stall_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: drives multiplexed display scans and checks the
// published frames against a frame-level reference model.
module tb_seg7_scan_capture;

    localparam int unsigned TIMEOUT = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_i;
    logic [6:0]  seg_i;
    logic [15:0] digits_o;
    logic [13:0] value_o;
    logic        valid_o;
    logic        glyph_err_o;
    logic        stall_o;

    int unsigned cyc = 0;
    int unsigned last_start = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] digits;
        logic [13:0] value;
        logic        err;
        int unsigned cyc;
    } pub_t;

    pub_t act_q[$];
    pub_t exp_q[$];

    // Lit patterns (active-high, bit0 = a) of the digits 0..9
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state (frame level)
    logic [15:0] m_frame;
    logic [3:0]  m_seen;
    logic [15:0] m_prev;
    bit          m_prev_ok;
    int          m_match;
    bit          m_pub;
    logic [15:0] m_digits;

    seg7_scan_capture dut (
        .clk         (clk),
        .reset       (reset),
        .an_i        (an_i),
        .seg_i       (seg_i),
        .digits_o    (digits_o),
        .value_o     (value_o),
        .valid_o     (valid_o),
        .glyph_err_o (glyph_err_o),
        .stall_o     (stall_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every publish pulse
    always @(negedge clk) begin
        if (valid_o) act_q.push_back('{digits_o, value_o, glyph_err_o, cyc});
    end

    function automatic logic [3:0] ref_decode(input logic [6:0] lit);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == lit) return 4'(i);
        if (lit == 7'h00) return 4'hF;
        if (lit == 7'h40) return 4'hE;
        return 4'hD;
    endfunction

    function automatic logic [6:0] lit_of(input logic [3:0] code);
        if (code <= 4'd9) return seg_tab[code];
        if (code == 4'hF) return 7'h00;
        if (code == 4'hE) return 7'h40;
        return 7'h49;
    endfunction

    function automatic void model_reset();
        m_frame = '0; m_seen = '0; m_prev = '0; m_prev_ok = 0;
        m_match = 0; m_pub = 0; m_digits = '0;
    endfunction

    // Apply the stability / publish rules to one completed frame
    function automatic void model_complete();
        int   val;
        logic err;
        logic [3:0] c;
        if (m_prev_ok && m_frame == m_prev) m_match = (m_match + 1 > 1) ? 1 : m_match + 1;
        else m_match = 0;
        m_prev = m_frame;
        m_prev_ok = 1;
        if (m_match >= 1 && (!m_pub || m_frame != m_digits)) begin
            val = 0; err = 0;
            for (int i = 3; i >= 0; i--) begin
                c = m_frame[i*4 +: 4];
                if (c == 4'hE || c == 4'hD) err = 1;
                val = val * 10 + ((c == 4'hF) ? 0 : int'(c));
            end
            if (err) val = 0;
            m_digits = m_frame;
            m_pub = 1;
            exp_q.push_back('{m_frame, 14'(val), err, 0});
        end
    endfunction

    function automatic void model_sample(input int pos, input logic [3:0] code);
        m_frame[pos*4 +: 4] = code;
        m_seen[pos] = 1'b1;
        if (m_seen == 4'hF) begin
            model_complete();
            m_seen = '0;
        end
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            an_i = 4'hF; seg_i = 7'h7F;
        end
    endtask

    task automatic drive_digit(input int pos, input logic [6:0] lit, input int dwell);
        for (int k = 0; k < dwell; k++) begin
            @(posedge clk); #1;
            if (k == 0) last_start = cyc;
            an_i  = ~(4'b0001 << pos);
            seg_i = ~lit;
        end
        if (dwell >= 5) model_sample(pos, ref_decode(lit));
    endtask

    task automatic drive_frame(input logic [15:0] codes, input int dwell);
        for (int pos = 3; pos >= 0; pos--) drive_digit(pos, lit_of(codes[pos*4 +: 4]), dwell);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; an_i = 4'hF; seg_i = 7'h7F;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (digits_o !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", digits_o); end
        checks++; if (value_o !== 14'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", value_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (glyph_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", glyph_err_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    endtask

    task automatic test_basic();
        act_q.delete();
        drive_frame(16'h1234, 8);
        drive_frame(16'h1234, 8);
        idle(6);
        checks++;
        if (act_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d pulses want 1", act_q.size());
        end else begin
            checks++; if (act_q[0].value !== 14'd1234) begin errors++; $display("FAIL basic_value: got %0d want 1234", act_q[0].value); end
            checks++; if (act_q[0].digits !== 16'h1234) begin errors++; $display("FAIL basic_digits: got %h want 1234", act_q[0].digits); end
            checks++; if (act_q[0].err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", act_q[0].err); end
            checks++; if (act_q[0].cyc != last_start + 6) begin errors++; $display("FAIL basic_latency: pulse at cycle %0d want %0d", act_q[0].cyc, last_start + 6); end
        end
    endtask

    task automatic test_short_dwell();
        act_q.delete();
        drive_digit(0, seg_tab[5], 3);
        idle(10);
        drive_digit(3, seg_tab[8], 8);
        drive_digit(2, seg_tab[8], 8);
        drive_digit(1, seg_tab[8], 8);
        idle(20);
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL short_dwell: got %0d pulses want 0", act_q.size()); end
    endtask

    task automatic test_blank();
        act_q.delete();
        for (int f = 0; f < 12; f++) drive_frame(16'hFF57, 8);
        idle(6);
        checks++;
        if (act_q.size() != 1) begin
            errors++; $display("FAIL blank_count: got %0d pulses want 1", act_q.size());
        end else begin
            checks++; if (act_q[0].value !== 14'd57) begin errors++; $display("FAIL blank_value: got %0d want 57", act_q[0].value); end
            checks++; if (act_q[0].digits !== 16'hFF57) begin errors++; $display("FAIL blank_digits: got %h want FF57", act_q[0].digits); end
            checks++; if (act_q[0].err !== 1'b0) begin errors++; $display("FAIL blank_err: got %b want 0", act_q[0].err); end
        end
    endtask

    task automatic test_dash();
        act_q.delete();
        drive_frame(16'hE123, 8);
        drive_frame(16'hE123, 8);
        idle(6);
        checks++;
        if (act_q.size() != 1) begin
            errors++; $display("FAIL dash_count: got %0d pulses want 1", act_q.size());
        end else begin
            checks++; if (act_q[0].err !== 1'b1) begin errors++; $display("FAIL dash_err: got %b want 1", act_q[0].err); end
            checks++; if (act_q[0].value !== 14'd0) begin errors++; $display("FAIL dash_value: got %0d want 0", act_q[0].value); end
            checks++; if (act_q[0].digits !== 16'hE123) begin errors++; $display("FAIL dash_digits: got %h want E123", act_q[0].digits); end
        end
    endtask

    task automatic test_alternate();
        act_q.delete();
        for (int f = 0; f < 6; f++) drive_frame((f % 2 == 0) ? 16'h1234 : 16'h1235, 8);
        idle(6);
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL alt_nomatch: got %0d pulses want 0", act_q.size()); end
        act_q.delete();
        drive_frame(16'h9999, 8);
        drive_frame(16'h9999, 8);
        idle(6);
        checks++;
        if (act_q.size() != 1) begin
            errors++; $display("FAIL alt_count: got %0d pulses want 1", act_q.size());
        end else begin
            checks++; if (act_q[0].value !== 14'd9999) begin errors++; $display("FAIL alt_value: got %0d want 9999", act_q[0].value); end
        end
    endtask

    task automatic test_random();
        logic [6:0] pool [2][4];
        int r;
        int sel;
        act_q.delete(); exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                r = $urandom_range(0, 13);
                if (r < 10)       pool[p][d] = seg_tab[r];
                else if (r == 10) pool[p][d] = 7'h00;
                else if (r == 11) pool[p][d] = 7'h40;
                else              pool[p][d] = 7'($urandom);
            end
        end
        for (int f = 0; f < 30; f++) begin
            sel = (f % 7 == 0) ? int'($urandom_range(0, 1)) : sel;
            for (int pos = 3; pos >= 0; pos--) drive_digit(pos, pool[sel][pos], int'($urandom_range(3, 9)));
        end
        idle(10);
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d pulses want %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i].digits !== exp_q[i].digits || act_q[i].value !== exp_q[i].value ||
                act_q[i].err !== exp_q[i].err) begin
                errors++;
                $display("FAIL rand_pub%0d: got %h/%0d/%b want %h/%0d/%b", i, act_q[i].digits,
                         act_q[i].value, act_q[i].err, exp_q[i].digits, exp_q[i].value, exp_q[i].err);
            end
        end
    endtask

    task automatic test_reset_mid_and_stall();
        drive_digit(3, seg_tab[7], 8);
        drive_digit(2, seg_tab[7], 8);
        drive_digit(1, seg_tab[7], 8);
        do_reset();
        drive_frame(16'h0042, 8);
        drive_frame(16'h0042, 8);
        idle(6);
        checks++;
        if (act_q.size() != 1) begin
            errors++; $display("FAIL midreset_count: got %0d pulses want 1", act_q.size());
        end else begin
            checks++; if (act_q[0].value !== 14'd42) begin errors++; $display("FAIL midreset_value: got %0d want 42", act_q[0].value); end
            checks++; if (act_q[0].digits !== 16'h0042) begin errors++; $display("FAIL midreset_digits: got %h want 0042", act_q[0].digits); end
        end
        idle(TIMEOUT - 200);
        @(negedge clk);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_early: got %b want 0", stall_o); end
        idle(400);
        @(negedge clk);
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_set: got %b want 1", stall_o); end
        drive_frame(16'h0042, 8);
        @(negedge clk);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b want 0", stall_o); end
    endtask

    initial begin
        reset = 1'b1;
        an_i  = 4'hF;
        seg_i = 7'h7F;
        model_reset();
        test_reset();
        test_basic();
        test_short_dwell();
        test_blank();
        test_dash();
        test_alternate();
        test_random();
        test_reset_mid_and_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
